// File: rtl/overlay_buffer_rotator.sv
// overlay_buffer_rotator: N-buffer frame rotator for the overlay path.
// Ports: clk, reset_n (sync, active-low), enable, vsync, frame_done in;
//   write_port, write_ready, read_port, frame_swap, queue_level out.
//   OVERLAY_ROTATOR_STATS_EN adds drop_count and swap_count outputs.
module overlay_buffer_rotator #(
  parameter int NUM_BUFFERS      = 3,
  parameter int PORT_W           = 3,
  parameter int QUEUE_MODE       = 0,
  parameter int VSYNC_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              vsync,
  input  logic              frame_done,
  output logic [PORT_W-1:0] write_port,
  output logic              write_ready,
  output logic [PORT_W-1:0] read_port,
  output logic              frame_swap,
  output logic [3:0]        queue_level
`ifdef OVERLAY_ROTATOR_STATS_EN
  ,
  output logic [15:0]       drop_count,
  output logic [15:0]       swap_count
`endif
);

  if (NUM_BUFFERS < 2 || NUM_BUFFERS > 8) begin : g_bad_n
    $error("NUM_BUFFERS must be 2..8");
  end
  if (QUEUE_MODE == 0 && NUM_BUFFERS < 3) begin : g_bad_mode
    $error("latest-frame mode needs NUM_BUFFERS >= 3");
  end
  if (PORT_W < $clog2(NUM_BUFFERS)) begin : g_bad_w
    $error("PORT_W too narrow for NUM_BUFFERS");
  end

  logic [PORT_W-1:0] q_q [NUM_BUFFERS];
  logic [PORT_W-1:0] q_n [NUM_BUFFERS];
  logic [3:0]        cnt_q, cnt_n;
  logic [PORT_W-1:0] disp_q, disp_n;
  logic [PORT_W-1:0] wr_q, wr_n;
  logic              wv_q, wv_n;
  logic              swap_q, swap_n;
  logic [3:0]        drops_n;
  logic              vs_prev;
  logic              vs_act;
  logic              vs_edge;
  logic [NUM_BUFFERS-1:0] busy;
  logic              found;

  assign vs_act  = (VSYNC_ACTIVE_LOW != 0) ? ~vsync : vsync;
  assign vs_edge = vs_act & ~vs_prev;

  // Completion, then swap, then allocation, all on the same
  // working copy so later steps see earlier effects.
  always_comb begin
    q_n     = q_q;
    cnt_n   = cnt_q;
    disp_n  = disp_q;
    wr_n    = wr_q;
    wv_n    = wv_q;
    swap_n  = 1'b0;
    drops_n = '0;
    busy    = '0;
    found   = 1'b0;

    if (frame_done && wv_q) begin
      for (int i = 0; i < NUM_BUFFERS; i++)
        if (4'(i) == cnt_q) q_n[i] = wr_q;
      cnt_n = cnt_q + 4'd1;
      wv_n  = 1'b0;
    end

    if (vs_edge && enable && cnt_n != 4'd0) begin
      swap_n = 1'b1;
      if (QUEUE_MODE != 0) begin
        disp_n = q_n[0];
        for (int i = 0; i < NUM_BUFFERS - 1; i++)
          q_n[i] = q_n[i+1];
        cnt_n = cnt_n - 4'd1;
      end else begin
        // Newest frame wins; everything older is discarded.
        for (int i = 0; i < NUM_BUFFERS; i++)
          if (4'(i) == cnt_n - 4'd1) disp_n = q_n[i];
        drops_n = cnt_n - 4'd1;
        cnt_n   = 4'd0;
      end
    end

    if (!wv_n) begin
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        busy[i] = (disp_n == PORT_W'(i));
        for (int j = 0; j < NUM_BUFFERS; j++)
          if (4'(j) < cnt_n && q_n[j] == PORT_W'(i))
            busy[i] = 1'b1;
      end
      // Descending scan so the lowest free index is kept.
      for (int i = NUM_BUFFERS - 1; i >= 0; i--)
        if (!busy[i]) begin
          wr_n  = PORT_W'(i);
          found = 1'b1;
        end
      if (found) begin
        wv_n = 1'b1;
      end else if (QUEUE_MODE == 0 && cnt_n != 4'd0) begin
        wr_n = q_n[0];
        for (int i = 0; i < NUM_BUFFERS - 1; i++)
          q_n[i] = q_n[i+1];
        cnt_n   = cnt_n - 4'd1;
        drops_n = drops_n + 4'd1;
        wv_n    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vs_prev <= 1'b0;
      disp_q  <= '0;
      wr_q    <= PORT_W'(1);
      wv_q    <= 1'b1;
      cnt_q   <= '0;
      swap_q  <= 1'b0;
      for (int i = 0; i < NUM_BUFFERS; i++)
        q_q[i] <= '0;
    end else begin
      vs_prev <= vs_act;
      disp_q  <= disp_n;
      wr_q    <= wr_n;
      wv_q    <= wv_n;
      cnt_q   <= cnt_n;
      swap_q  <= swap_n;
      for (int i = 0; i < NUM_BUFFERS; i++)
        q_q[i] <= q_n[i];
    end
  end

  assign write_port  = wr_q;
  assign write_ready = wv_q;
  assign read_port   = disp_q;
  assign frame_swap  = swap_q;
  assign queue_level = cnt_q;

`ifdef OVERLAY_ROTATOR_STATS_EN
  logic [15:0] drop_q, swapc_q;
  logic [16:0] drop_sum;

  assign drop_sum = {1'b0, drop_q} + 17'(drops_n);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drop_q  <= '0;
      swapc_q <= '0;
    end else begin
      drop_q  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (swap_n) swapc_q <= swapc_q + 16'd1;
    end
  end

  assign drop_count = drop_q;
  assign swap_count = swapc_q;
`else
  logic drops_unused;
  assign drops_unused = ^drops_n;
`endif

endmodule

// File: tb/tb_overlay_buffer_rotator.sv
// tb_overlay_buffer_rotator: scoreboard bench for three rotator builds
// (N=3 latest-frame, N=2 queue, N=4 queue) driven by directed vectors.
module tb_overlay_buffer_rotator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       en [3];
  logic       vs [3];
  logic       fd [3];
  logic [2:0] rp [3];
  logic [2:0] wp [3];
  logic       wr [3];
  logic       fs [3];
  logic [3:0] ql [3];
`ifdef OVERLAY_ROTATOR_STATS_EN
  logic [15:0] dc [3];
  logic [15:0] sc [3];
`endif

  overlay_buffer_rotator #(.NUM_BUFFERS(3), .QUEUE_MODE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .enable(en[0]), .vsync(vs[0]),
    .frame_done(fd[0]), .write_port(wp[0]), .write_ready(wr[0]),
    .read_port(rp[0]), .frame_swap(fs[0]), .queue_level(ql[0])
`ifdef OVERLAY_ROTATOR_STATS_EN
    , .drop_count(dc[0]), .swap_count(sc[0])
`endif
  );

  overlay_buffer_rotator #(.NUM_BUFFERS(2), .QUEUE_MODE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .enable(en[1]), .vsync(vs[1]),
    .frame_done(fd[1]), .write_port(wp[1]), .write_ready(wr[1]),
    .read_port(rp[1]), .frame_swap(fs[1]), .queue_level(ql[1])
`ifdef OVERLAY_ROTATOR_STATS_EN
    , .drop_count(dc[1]), .swap_count(sc[1])
`endif
  );

  overlay_buffer_rotator #(.NUM_BUFFERS(4), .QUEUE_MODE(1)) u2 (
    .clk(clk), .reset_n(reset_n), .enable(en[2]), .vsync(vs[2]),
    .frame_done(fd[2]), .write_port(wp[2]), .write_ready(wr[2]),
    .read_port(rp[2]), .frame_swap(fs[2]), .queue_level(ql[2])
`ifdef OVERLAY_ROTATOR_STATS_EN
    , .drop_count(dc[2]), .swap_count(sc[2])
`endif
  );

  typedef struct {
    int         cyc;
    int         d;
    string      nm;
    logic [2:0] rp;
    logic [2:0] wp;
    logic       wr;
    logic       fs;
    logic [3:0] ql;
    int         dc;
    int         sc;
  } exp_t;

  exp_t sb [$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t e;
  logic bad;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation due at this sample point.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      bad = (e.cyc != cyc);
      if (rp[e.d] !== e.rp) bad = 1'b1;
      if (wr[e.d] !== e.wr) bad = 1'b1;
      if (e.wr && wp[e.d] !== e.wp) bad = 1'b1;
      if (fs[e.d] !== e.fs) bad = 1'b1;
      if (ql[e.d] !== e.ql) bad = 1'b1;
`ifdef OVERLAY_ROTATOR_STATS_EN
      if (e.dc >= 0 && dc[e.d] !== 16'(e.dc)) bad = 1'b1;
      if (e.sc >= 0 && sc[e.d] !== 16'(e.sc)) bad = 1'b1;
`endif
      if (bad) begin
        failures++;
        $display("FAIL %s dut%0d cyc%0d: got rp=%0d wp=%0d wr=%0b fs=%0b ql=%0d want rp=%0d wp=%0d wr=%0b fs=%0b ql=%0d dc=%0d sc=%0d",
                 e.nm, e.d, cyc, rp[e.d], wp[e.d], wr[e.d], fs[e.d],
                 ql[e.d], e.rp, e.wp, e.wr, e.fs, e.ql, e.dc, e.sc);
      end
    end
  end

  task automatic push(input int c, input int d, input string nm,
                      input int erp, input int ewp, input int ewr,
                      input int efs, input int eql,
                      input int edc, input int esc);
    exp_t x;
    x.cyc = c;
    x.d   = d;
    x.nm  = nm;
    x.rp  = 3'(erp);
    x.wp  = 3'(ewp);
    x.wr  = ewr[0];
    x.fs  = efs[0];
    x.ql  = 4'(eql);
    x.dc  = edc;
    x.sc  = esc;
    sb.push_back(x);
  endtask

  // One cycle of stimulus on dut d; va is the active-ness of vsync.
  task automatic step(input int d, input logic f, input logic va,
                      input logic en_v, input string nm,
                      input int erp, input int ewp, input int ewr,
                      input int efs, input int eql,
                      input int edc = -1, input int esc = -1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) fd[k] = 1'b0;
    fd[d] = f;
    vs[d] = ~va;
    en[d] = en_v;
    push(cyc + 1, d, nm, erp, ewp, ewr, efs, eql, edc, esc);
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fd[k] = 1'b0;
      vs[k] = 1'b1;
      en[k] = 1'b1;
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++)
      push(cyc, k, nm, 0, 1, 1, 0, 0, 0, 0);
  endtask

  initial begin
    int t;
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fd[k] = 1'b0;
      vs[k] = 1'b1;
      en[k] = 1'b1;
    end

    do_reset("rst_init");
    step(0, 0, 0, 1, "a_idle",     0, 1, 1, 0, 0);
    step(0, 0, 1, 1, "a_vs_empty", 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, "a_vs_low",   0, 1, 1, 0, 0);
    step(0, 1, 0, 1, "b_done",     0, 2, 1, 0, 1);
    step(0, 0, 1, 1, "b_swap",     1, 2, 1, 1, 0, 0, 1);
    step(0, 0, 1, 1, "b_hold",     1, 2, 1, 0, 0);
    step(0, 0, 0, 1, "b_low",      1, 2, 1, 0, 0);
    step(0, 1, 0, 1, "b_free0",    1, 0, 1, 0, 1);

    do_reset("rst_c");
    step(0, 1, 0, 1, "c_done1",    0, 2, 1, 0, 1);
    step(0, 1, 0, 1, "c_reclaim",  0, 1, 1, 0, 1, 1, 0);
    step(0, 0, 1, 1, "c_swap",     2, 1, 1, 1, 0, 1, 1);
    step(0, 0, 0, 1, "c_low",      2, 1, 1, 0, 0);

    do_reset("rst_f");
    step(0, 1, 1, 1, "f_coinc",    1, 0, 1, 1, 0, 0, 1);
    step(0, 0, 1, 1, "f_hold",     1, 0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 1, "f_low",      1, 0, 1, 0, 0);

    do_reset("rst_d");
    step(1, 1, 0, 1, "d_full",     0, 1, 0, 0, 1);
    step(1, 1, 0, 1, "d_ignored",  0, 1, 0, 0, 1);
    step(1, 0, 1, 1, "d_swap",     1, 0, 1, 1, 0);
    step(1, 0, 0, 1, "d_low",      1, 0, 1, 0, 0);

    do_reset("rst_e");
    step(2, 1, 0, 1, "e_done1",    0, 2, 1, 0, 1);
    step(2, 1, 0, 1, "e_done2",    0, 3, 1, 0, 2);
    step(2, 1, 0, 1, "e_done3",    0, 3, 0, 0, 3);
    step(2, 0, 1, 1, "e_swap1",    1, 0, 1, 1, 2);
    step(2, 0, 0, 1, "e_low1",     1, 0, 1, 0, 2);
    step(2, 0, 1, 0, "e_vs_dis",   1, 0, 1, 0, 2);
    step(2, 0, 1, 1, "e_en_hold",  1, 0, 1, 0, 2);
    step(2, 0, 0, 1, "e_low2",     1, 0, 1, 0, 2);
    step(2, 0, 1, 1, "e_swap2",    2, 0, 1, 1, 1);
    step(2, 0, 0, 1, "e_low3",     2, 0, 1, 0, 1);
    step(2, 0, 1, 1, "e_swap3",    3, 0, 1, 1, 0, 0, 3);
    step(2, 1, 0, 1, "e_mid",      3, 1, 1, 0, 1);

    do_reset("rst_mid");

    t = 0;
    while (sb.size() > 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/overlay_buffer_rotator.md
# overlay_buffer_rotator

N-buffer frame rotator for the overlay path. It generalises the fixed two-port overlay buffer switcher into a parametrised triple-or-more buffering manager. The writer side (Nios PIO or a DMA master) is handed a free buffer index and pulses `frame_done` when a frame is complete. Completed frames are promoted to the display index on the active edge of VGA vsync, which the video read buffer uses as its base-address select. It sits in the qsys clock domain between the overlay PIOs and the `vid_read_buffer` port input.

## Interface
- `NUM_BUFFERS`, 3 — number of frame buffers, 2..8. `QUEUE_MODE=0` requires ≥3, otherwise elaboration error.
- `PORT_W`, 3 — index width, must be ≥ clog2(NUM_BUFFERS).
- `QUEUE_MODE`, 0 — 0 = latest-frame (drop stale frames), 1 = in-order queue (writer stalls when full).
- `VSYNC_ACTIVE_LOW`, 1 — polarity of `vsync`.
- `clk`  in  1  — qsys clock. One clock only.
- `reset_n`  in  1  — reset, synchronous, active-low.
- `enable`  in  1  — 1 = display swaps allowed; 0 = display index frozen.
- `vsync`  in  1  — VGA vsync, already synchronised to `clk`.
- `frame_done`  in  1  — one-cycle pulse: current write buffer complete.
- `write_port`  out  PORT_W  — buffer the writer must fill.
- `write_ready`  out  1  — `write_port` valid; writing permitted.
- `read_port`  out  PORT_W  — buffer being displayed.
- `frame_swap`  out  1  — one-cycle pulse when `read_port` changes.
- `queue_level`  out  4  — completed frames waiting for display.

## Operation
- Each buffer has exactly one state: FREE, WRITING, READY (in the ordered ready queue) or DISPLAY. Exactly one buffer is in DISPLAY at all times.
- Reset values:
  - buffer 0 DISPLAY, buffer 1 WRITING, others FREE
  - `read_port`=0, `write_port`=1, `write_ready`=1
  - `frame_swap`=0, `queue_level`=0, queue empty
  - vsync history = inactive level
- Per-cycle processing order: (1) completion, (2) vsync swap, (3) write allocation. Events from (1) and (2) are visible to (3) in the same cycle.
- Completion (`frame_done`=1 and `write_ready`=1): the WRITING buffer is appended to the queue tail. `frame_done` while `write_ready`=0 is ignored.
- Vsync swap, triggered by an active edge (vsync active now, inactive last cycle) with `enable`=1 and queue non-empty:
  - old DISPLAY becomes FREE
  - `QUEUE_MODE=1`: queue head becomes DISPLAY
  - `QUEUE_MODE=0`: queue tail (newest) becomes DISPLAY; all older queue entries become FREE and each counts as a drop
  - `frame_swap` pulses.
- An edge with an empty queue or `enable`=0 makes no change and no pulse.
- Write allocation (only if no buffer is WRITING): take the lowest-index FREE buffer.
  - If none is FREE and `QUEUE_MODE=0`: reclaim the queue head (oldest READY) as WRITING and count one drop.
  - If none is FREE and `QUEUE_MODE=1`: `write_ready`=0 until a vsync swap frees a buffer.
- `queue_level` equals the current queue occupancy. Maximum is NUM_BUFFERS−1 in queue mode and NUM_BUFFERS−2 in latest mode.
- `enable` low affects only swaps. Completions and drops continue.
- Reset asserted mid-frame returns all state to the reset values on the next edge. No partial state survives.

## Timing
- `frame_done` sampled at edge k: `write_port`, `write_ready` and `queue_level` update at edge k (visible in cycle k+1).
- `vsync` first sampled active at edge k: `read_port`, `frame_swap`=1 and `queue_level` update at edge k. `frame_swap` returns to 0 at edge k+1.
- Vsync held active for multiple cycles produces only one swap. A new swap requires vsync to go inactive and then active again.
- `frame_done` and a vsync edge in the same cycle: the just-completed frame is eligible for that swap. The buffer released by the swap is eligible for allocation in that same cycle.
- If vsync is active when reset releases, an edge is detected in the first cycle. It is harmless because the queue is empty.

## Configuration
- `OVERLAY_ROTATOR_STATS_EN` defined: adds two 16-bit output ports.
  - `drop_count`, saturating at 0xFFFF.
  - `swap_count`, wrapping.
  - Both reset to 0. Each increments at the same edge as the event it counts. Multiple drops in one cycle add their total.
- Macro undefined: neither port nor its counters exist. All other behaviour is identical.

## Test plan
- Reset release, N=3, mode 0: `read_port`=0, `write_port`=1, `write_ready`=1, `queue_level`=0; a vsync edge with an empty queue gives no `frame_swap`.
- N=3, mode 0: `frame_done`, then vsync edge -> `read_port`=1, `frame_swap` high for 1 cycle, `write_port`=2, buffer 0 FREE.
- N=3, mode 0: two `frame_done` pulses, no vsync -> second completion reclaims buffer 1, `write_port`=1, `queue_level`=1, `drop_count`=1; next vsync -> `read_port`=2.
- N=2, mode 1: `frame_done` -> `write_ready`=0, `queue_level`=1; extra `frame_done` is ignored; vsync -> `read_port`=1, `write_port`=0, `write_ready`=1.
- N=4, mode 1: `frame_done` ×3, then 3 vsync edges -> `read_port` sequence 1, 2, 3 in order; `enable`=0 during the 2nd vsync delays that swap to the next edge.
- `frame_done` coincident with the vsync edge, N=3 mode 0, empty queue -> `read_port`=1 and `write_port`=0 at the same edge.
